// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage feeding the C-bus destination mux (MUX_C).
//   Holds the program counter, reads instruction words from memory over a
//   req/ack handshake, latches them into the instruction register and
//   exposes the decoded register fields plus the return address pc_1.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   fetch_en          start a fetch at pc (honoured in IDLE only)
//   branch_en         load pc from branch_target (IDLE only, wins over fetch)
//   branch_target     branch destination
//   mem_req/mem_addr  memory read request, held until mem_ack
//   mem_ack/mem_rdata one-cycle acknowledge with read data
//   ir, ir_valid      instruction register and one-cycle update pulse
//   busy              high while a fetch is in flight (REQ or DONE)
//   pc, ir_pc, pc_1   next fetch address, address of ir, ir_pc + 1
//   opcode, registerC, registerA, registerB   decoded fields of ir
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    output logic               busy,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic [ADDR_W-1:0]  pc_1,
    output logic [3:0]         opcode,
    output logic [2:0]         registerC,
    output logic [2:0]         registerA,
    output logic [2:0]         registerB
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    // All outputs are registered; busy and ir_valid are set on entry to the
    // state they describe so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= '0;
            ir_pc    <= '0;
            ir       <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            ir_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            ir_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // A branch in the same cycle as a fetch drops the fetch.
                    if (branch_en) begin
                        pc <= branch_target;
                    end else if (fetch_en) begin
                        mem_addr <= pc;
                        mem_req  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    // Wait indefinitely; mem_addr is held for the whole request.
                    if (mem_ack) begin
                        ir       <= mem_rdata;
                        ir_pc    <= mem_addr;
                        pc       <= mem_addr + 1'b1;
                        mem_req  <= 1'b0;
                        ir_valid <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Decoded fields and return address track ir / ir_pc directly.
    assign pc_1      = ir_pc + 1'b1;
    assign opcode    = ir[15:12];
    assign registerC = ir[11:9];
    assign registerA = ir[8:6];
    assign registerB = ir[5:3];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        branch_en;
    logic [7:0]  branch_target;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir;
    logic        ir_valid;
    logic        busy;
    logic [7:0]  pc;
    logic [7:0]  ir_pc;
    logic [7:0]  pc_1;
    logic [3:0]  opcode;
    logic [2:0]  registerC;
    logic [2:0]  registerA;
    logic [2:0]  registerB;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level reference: architectural registers only.
    int m_pc, m_ir, m_ir_pc;

    fetch_unit #(.ADDR_W(8), .INSTR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .branch_en(branch_en),
        .branch_target(branch_target), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .ir_valid(ir_valid),
        .busy(busy), .pc(pc), .ir_pc(ir_pc), .pc_1(pc_1), .opcode(opcode),
        .registerC(registerC), .registerA(registerA), .registerB(registerB)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_arch(input string tag);
        check({tag, ".pc"},    int'(pc),        m_pc);
        check({tag, ".ir"},    int'(ir),        m_ir);
        check({tag, ".ir_pc"}, int'(ir_pc),     m_ir_pc);
        check({tag, ".pc_1"},  int'(pc_1),      (m_ir_pc + 1) % 256);
        check({tag, ".opc"},   int'(opcode),    m_ir / 4096);
        check({tag, ".rC"},    int'(registerC), (m_ir / 512) % 8);
        check({tag, ".rA"},    int'(registerA), (m_ir / 64) % 8);
        check({tag, ".rB"},    int'(registerB), (m_ir / 8) % 8);
    endtask

    task automatic do_branch(input int target, input bit with_fetch);
        branch_en     = 1'b1;
        branch_target = target[7:0];
        fetch_en      = with_fetch;
        tick();
        branch_en = 1'b0;
        fetch_en  = 1'b0;
        m_pc = target % 256;
        check("br.mem_req", int'(mem_req), 0);
        check("br.busy",    int'(busy),    0);
        check_arch("br");
        tick();
        check("br.idle_req", int'(mem_req), 0);
    endtask

    // Full fetch: ack lands 'delay' cycles after mem_req rises (delay >= 1).
    // With noise, ignored inputs are driven during REQ and DONE.
    task automatic do_fetch(input int delay, input int rdata, input bit noise);
        int addr;
        addr = m_pc;
        fetch_en = 1'b1;
        tick();
        fetch_en = noise;
        if (noise) begin
            branch_en     = 1'b1;
            branch_target = 8'h77;
        end
        check("f.req_rise", int'(mem_req), 1);
        check("f.addr",     int'(mem_addr), addr);
        check("f.busy",     int'(busy),     1);
        for (int i = 1; i < delay; i++) begin
            tick();
            check("f.req_hold",  int'(mem_req),  1);
            check("f.addr_hold", int'(mem_addr), addr);
            check("f.pc_hold",   int'(pc),       addr);
            check("f.nvalid",    int'(ir_valid), 0);
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata[15:0];
        tick();
        mem_ack = 1'b0;
        m_ir    = rdata % 65536;
        m_ir_pc = addr;
        m_pc    = (addr + 1) % 256;
        check("f.valid",    int'(ir_valid), 1);
        check("f.req_fall", int'(mem_req),  0);
        check("f.busy_d",   int'(busy),     1);
        check_arch("f.done");
        tick();
        fetch_en  = 1'b0;
        branch_en = 1'b0;
        check("f.valid_off", int'(ir_valid), 0);
        check("f.busy_off",  int'(busy),     0);
        check("f.no_req",    int'(mem_req),  0);
        check_arch("f.idle");
        if (noise) begin
            tick();
            check("f.no_2nd_req", int'(mem_req), 0);
        end
    endtask

    task automatic idle_ack();
        mem_ack   = 1'b1;
        mem_rdata = 16'($urandom);
        tick();
        mem_ack = 1'b0;
        check("ia.req",   int'(mem_req),  0);
        check("ia.valid", int'(ir_valid), 0);
        check_arch("ia");
    endtask

    initial begin
        rst_n = 1'b0; fetch_en = 1'b1; branch_en = 1'b0; branch_target = '0;
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        tick(); tick();
        m_pc = 0; m_ir = 0; m_ir_pc = 0;
        check("rst.mem_req",  int'(mem_req),  0);
        check("rst.valid",    int'(ir_valid), 0);
        check("rst.busy",     int'(busy),     0);
        check("rst.mem_addr", int'(mem_addr), 0);
        check_arch("rst");
        rst_n = 1'b1; fetch_en = 1'b0; mem_ack = 1'b0;
        tick();
        check("rst.idle_req", int'(mem_req), 0);

        // Single fetch at 0x10, ack two cycles after request
        do_branch(8'h10, 1'b0);
        do_fetch(2, 16'hA6C8, 1'b0);

        // Wrap at top of address space
        do_branch(8'hFF, 1'b0);
        do_fetch(1, 16'h1234, 1'b0);
        do_fetch(1, 16'h0F0F, 1'b0);

        // Branch wins over a simultaneous fetch
        do_branch(8'h40, 1'b1);
        do_fetch(3, 16'h5555, 1'b0);

        // Ignored inputs in REQ/DONE and ack while idle
        do_fetch(2, 16'hBEEF, 1'b1);
        idle_ack();

        // Reset while request is outstanding
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        check("mr.req", int'(mem_req), 1);
        rst_n = 1'b0;
        tick();
        m_pc = 0; m_ir = 0; m_ir_pc = 0;
        check("mr.req_clr", int'(mem_req), 0);
        check_arch("mr.rst");
        rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hCAFE;
        tick();
        mem_ack = 1'b0;
        check("mr.nvalid", int'(ir_valid), 0);
        check("mr.busy",   int'(busy),     0);
        check_arch("mr.ack");
        tick();
        check("mr.nvalid2", int'(ir_valid), 0);
        check("mr.req2",    int'(mem_req),  0);

        // Randomized mix of operations
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0: do_branch(int'($urandom_range(0, 255)), 1'($urandom));
                1: idle_ack();
                default: do_fetch(int'($urandom_range(1, 4)),
                                  int'($urandom_range(0, 65535)), 1'($urandom));
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
